// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision FP units: word layout,
// constants and the scheduler state encoding.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/div_fp.sv
// Combinational single-precision divider: truncated quotient, exponent
// saturated to infinity / flushed to zero; valid_out low on nonzero / zero.
module div_fp
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            valid_in,
    output logic [FP_W-1:0] out,
    output logic            valid_out
);

    localparam int MW = FP_MAN_W + 1;
    localparam logic signed [FP_EXP_W+1:0] E_BIAS = 10'sd127;
    localparam logic signed [FP_EXP_W+1:0] E_MAX  = 10'sd255;

    logic        [MW-1:0]       man_a;
    logic        [MW-1:0]       man_b;
    logic        [2*MW-1:0]     num;
    logic        [2*MW-1:0]     den;
    logic        [MW:0]         quo;
    logic signed [FP_EXP_W+1:0] exp_q;
    logic        [FP_MAN_W-1:0] frac_q;

    function automatic logic [FP_W-1:0] pack_sat(
        input logic                        s,
        input logic signed [FP_EXP_W+1:0]  e,
        input logic        [FP_MAN_W-1:0]  f
    );
        if (e >= E_MAX)
            return {s, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
        else if (e <= 10'sd0)
            return FP_ZERO;
        else
            return {s, e[FP_EXP_W-1:0], f};
    endfunction

    assign man_a = {1'b1, a[FP_MAN_W-1:0]};
    assign man_b = {1'b1, b[FP_MAN_W-1:0]};
    assign num   = {man_a, {MW{1'b0}}};
    assign den   = {{MW{1'b0}}, man_b};

    // Mantissa ratio lies in (0.5, 2): quo carries 24 fractional bits and
    // its top bit says whether the result needs a one-place renormalise.
    assign quo    = (MW+1)'(num / den);
    assign frac_q = quo[MW] ? quo[MW-1:1] : quo[MW-2:0];
    assign exp_q  = $signed({2'b00, a[FP_W-2:FP_MAN_W]})
                  - $signed({2'b00, b[FP_W-2:FP_MAN_W]})
                  + E_BIAS
                  - $signed({9'd0, ~quo[MW]});

    always_comb begin
        out       = FP_ZERO;
        valid_out = 1'b0;
        if (valid_in) begin
            if (a == FP_ZERO) begin
                valid_out = 1'b1;
            end else if (b == FP_ZERO) begin
                valid_out = 1'b0;
            end else begin
                out       = pack_sat(a[FP_W-1] ^ b[FP_W-1], exp_q, frac_q);
                valid_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// above ptr, wrapping at N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                gnt[(int'(ptr) + i) % N] = 1'b1;
                found                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Round-robin scheduler sharing one combinational div_fp among NUM_REQ
// requesters; operands are held for SETTLE_CYCLES before the quotient is taken.
module fpdiv_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [FP_W-1:0]         resp_data,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [PTR_W-1:0] grant_idx;
    logic [CNT_W-1:0] cnt_q;
    logic [FP_W-1:0]  op_a_q;
    logic [FP_W-1:0]  op_b_q;
    logic [FP_W-1:0]  res_data_q;
    logic             res_err_q;

    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic               capture;
    logic               div_valid_in;
    logic [FP_W-1:0]    div_out;
    logic               div_valid_out;

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) idx = PTR_W'(i);
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1)
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // The divider sees only the latched operands, so requester-side changes
    // during the settle window cannot disturb the long combinational path.
    div_fp u_div (
        .a         (op_a_q),
        .b         (op_b_q),
        .valid_in  (div_valid_in),
        .out       (div_out),
        .valid_out (div_valid_out)
    );

    assign div_valid_in = (state_q != ST_IDLE);
    assign accept       = |(req_valid & req_ready);
    assign grant_idx    = onehot_idx(gnt);
    assign capture      = (state_q == ST_WAIT) && (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = FP_ZERO;
        resp_err   = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: if (accept)              state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0)         state_d = ST_DONE;
            ST_DONE: if (resp_ready[owner_q]) state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase

        if (!rst) begin
            busy = (state_q != ST_IDLE);
            if (state_q == ST_IDLE)
                req_ready = gnt;
            if (state_q == ST_DONE) begin
                resp_valid[owner_q] = 1'b1;
                resp_data           = res_data_q;
                resp_err            = res_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            owner_q    <= '0;
            op_a_q     <= FP_ZERO;
            op_b_q     <= FP_ZERO;
            res_data_q <= FP_ZERO;
            res_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q   <= req_a[FP_W*grant_idx +: FP_W];
                op_b_q   <= req_b[FP_W*grant_idx +: FP_W];
                owner_q  <= grant_idx;
                rr_ptr_q <= wrap_inc(grant_idx);
                cnt_q    <= CNT_LOAD;
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                res_data_q <= div_out;
                res_err_q  <= ~div_valid_out;
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed and randomized checks of fpdiv_arbiter against a queue-free
// behavioural model: exact integer quotients and a pointer-order grant rule.
module tb_fpdiv_arbiter;

    localparam int NR     = 4;
    localparam int SETTLE = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [32*NR-1:0] req_a;
    logic [32*NR-1:0] req_b;
    logic [NR-1:0]  resp_valid;
    logic [NR-1:0]  resp_ready;
    logic [31:0]    resp_data;
    logic           resp_err;
    logic           busy;

    logic [31:0] ex_d [NR];
    logic        ex_e [NR];
    int          ptr_m;
    int          checks = 0;
    int          errors = 0;

    fpdiv_arbiter #(.NUM_REQ(NR), .SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-precision encoding of v * 2^sh for an integer v < 2^24.
    function automatic logic [31:0] fp_of(input int unsigned v, input int sh, input logic s);
        int p;
        p = 0;
        for (int k = 0; k < 24; k++)
            if (v[k]) p = k;
        return {s, 8'(127 + p + sh), 23'(v << (23 - p))};
    endfunction

    function automatic int pick(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[(ptr_m + i) % NR]) return (ptr_m + i) % NR;
        return -1;
    endfunction

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic e);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        ex_d[i]           = d;
        ex_e[i]           = e;
        req_valid[i]      = 1'b1;
    endtask

    // Quotient x*2^(sa-sb) built from a = (x*y)*2^sa and b = y*2^sb, so it
    // is exact and independent of the divider's rounding.
    task automatic rand_op(input int i);
        int unsigned x, y;
        int          sa, sb, sel;
        logic        s1, s2;
        x   = $urandom_range(4095, 1);
        y   = $urandom_range(4095, 1);
        sa  = int'($urandom_range(40, 0)) - 20;
        sb  = int'($urandom_range(40, 0)) - 20;
        s1  = 1'($urandom);
        s2  = 1'($urandom);
        sel = int'($urandom_range(7, 0));
        if (sel == 0)
            load(i, 32'h0, fp_of(y, sb, s2), 32'h0, 1'b0);
        else if (sel == 1)
            load(i, fp_of(x * y, sa, s1), 32'h0, 32'h0, 1'b1);
        else
            load(i, fp_of(x * y, sa, s1), fp_of(y, sb, s2), fp_of(x, sa - sb, s1 ^ s2), 1'b0);
    endtask

    // Called in an IDLE cycle just after the falling edge; returns at the
    // falling edge of the cycle after the owner accepted its response.
    task automatic serve_one(input int g, input int bp);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("grant", 32'(req_ready), 32'(1) << g);
        ptr_m = (g + 1) % NR;
        for (int k = 1; k <= SETTLE; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid[g]      = 1'b0;
                req_a[32*g +: 32] = $urandom;
                req_b[32*g +: 32] = $urandom;
                resp_ready        = ~(NR'(1) << g);
            end
            #1;
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_ready", 32'(req_ready), 32'd0);
            chk("wait_resp_valid", 32'(resp_valid), 32'd0);
        end
        for (int d = 0; d <= bp; d++) begin
            @(negedge clk);
            resp_ready[g] = (d == bp);
            #1;
            chk("resp_valid", 32'(resp_valid), 32'(1) << g);
            chk("resp_data", resp_data, ex_d[g]);
            chk("resp_err", 32'(resp_err), 32'(ex_e[g]));
            chk("done_busy", 32'(busy), 32'd1);
            chk("done_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = '0;
    endtask

    initial begin
        int g;
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        ptr_m      = 0;
        for (int i = 0; i < NR; i++) begin
            ex_d[i] = 32'h0;
            ex_e[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("idle_no_req", 32'(req_ready), 32'd0);

        // 6.0 / 2.0, then zero dividend and divide-by-zero
        @(negedge clk);
        load(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        serve_one(0, 0);
        load(1, 32'h00000000, 32'h3F800000, 32'h00000000, 1'b0);
        serve_one(1, 0);
        load(2, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b1);
        serve_one(2, 0);
        rand_op(3);
        serve_one(3, 1);

        // All four together, then only 1 and 3
        for (int i = 0; i < NR; i++) rand_op(i);
        serve_one(0, 0);
        serve_one(1, 0);
        serve_one(2, 0);
        serve_one(3, 0);
        rand_op(1);
        rand_op(3);
        serve_one(1, 0);
        serve_one(3, 2);

        // Backpressure on owner 0 with req1 pending
        rand_op(0);
        rand_op(1);
        serve_one(0, 5);
        serve_one(1, 0);

        // Reset in the second WAIT cycle
        rand_op(1);
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rand_op(2);
        #1;
        chk("rst_hi_ready", 32'(req_ready), 32'd0);
        chk("rst_hi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd0);
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_resp_data", resp_data, 32'd0);
        chk("post_rst_resp_err", 32'(resp_err), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        serve_one(2, 0);

        // Reset in IDLE with the pointer away from 0, then random traffic
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(1, 0) == 1) rand_op(i);
            if ($urandom_range(3, 0) == 0)
                req_valid[$urandom_range(NR - 1, 0)] = 1'b0;
            if (req_valid == '0)
                rand_op(it % NR);
            g = pick(req_valid);
            serve_one(g, int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
